// File: rtl/line_mem_arbiter.sv
// Single-port line memory arbiter: core has fixed priority, host gets a starvation guard
// and a burst lock. Optional stall/grant statistics are enabled with LINE_MEM_ARB_STATS_EN.
module line_mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int LOAD_LATENCY = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_core_re,
    input  logic                  i_core_we,
    input  logic [ADDR_WIDTH-1:0] i_core_addr,
    input  logic [DATA_WIDTH-1:0] i_core_wdata,
    output logic                  o_core_stall,
    output logic [DATA_WIDTH-1:0] o_core_rdata,
    output logic                  o_core_rvld,
    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic                  i_host_lock,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    output logic                  o_host_gnt,
    output logic [DATA_WIDTH-1:0] o_host_rdata,
    output logic                  o_host_rvld,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    input  logic                  i_mem_rvld,
    output logic [15:0]           o_stall_cycles,
    output logic [15:0]           o_host_grants
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CORE = 2'd1,
        S_HOST = 2'd2,
        S_LOCK = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    state_t                  state_r;
    logic [3:0]              starve_cnt_r;
    logic [LOAD_LATENCY-1:0] pipe_vld_r;
    logic [LOAD_LATENCY-1:0] pipe_host_r;

    logic creq_s;
    logic core_rd_s;
    logic core_wins_s;
    logic host_sel_s;
    logic host_wins_s;
    logic stall_s;
    logic mem_re_s;
    logic tail_vld_s;
    logic tail_host_s;

    // Winner selection; a locked host owns the port even while idle
    always_comb begin
        creq_s      = i_core_re | i_core_we;
        core_rd_s   = i_core_re & ~i_core_we;
        core_wins_s = 1'b0;
        host_sel_s  = 1'b0;
        if (state_r == S_LOCK) begin
            host_sel_s = 1'b1;
        end else if (i_host_req && (starve_cnt_r == STARVE_MAX)) begin
            host_sel_s = 1'b1;
        end else if (creq_s) begin
            core_wins_s = 1'b1;
        end else begin
            host_sel_s = i_host_req;
        end
        host_wins_s = host_sel_s & i_host_req;
        stall_s     = creq_s & ~core_wins_s;
    end

    // Memory port mux of the winning requester's fields
    always_comb begin
        if (core_wins_s) begin
            mem_re_s    = core_rd_s;
            o_mem_we    = i_core_we;
            o_mem_addr  = i_core_addr;
            o_mem_wdata = i_core_wdata;
        end else if (host_wins_s) begin
            mem_re_s    = ~i_host_we;
            o_mem_we    = i_host_we;
            o_mem_addr  = i_host_addr;
            o_mem_wdata = i_host_wdata;
        end else begin
            mem_re_s    = 1'b0;
            o_mem_we    = 1'b0;
            o_mem_addr  = {ADDR_WIDTH{1'b0}};
            o_mem_wdata = {DATA_WIDTH{1'b0}};
        end
    end

    assign o_mem_re     = mem_re_s;
    assign o_host_gnt   = host_wins_s;
    assign o_core_stall = stall_s;

    // Owner FSM: remembers last cycle's owner and holds the burst lock
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_r <= S_IDLE;
        end else begin
            case (state_r)
                S_LOCK: begin
                    if (i_host_lock) begin
                        state_r <= S_LOCK;
                    end else if (host_wins_s) begin
                        state_r <= S_HOST;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    if (core_wins_s) begin
                        state_r <= S_CORE;
                    end else if (host_wins_s) begin
                        state_r <= i_host_lock ? S_LOCK : S_HOST;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Host starvation counter, saturating at the forced-grant threshold
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            starve_cnt_r <= 4'd0;
        end else if (i_host_req && !host_wins_s) begin
            if (starve_cnt_r != STARVE_MAX) begin
                starve_cnt_r <= starve_cnt_r + 4'd1;
            end else begin
                starve_cnt_r <= starve_cnt_r;
            end
        end else begin
            starve_cnt_r <= 4'd0;
        end
    end

    // Read-owner tag pipe, aligned with the fixed memory load latency
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pipe_vld_r  <= {LOAD_LATENCY{1'b0}};
            pipe_host_r <= {LOAD_LATENCY{1'b0}};
        end else begin
            pipe_vld_r[0]  <= mem_re_s;
            pipe_host_r[0] <= host_wins_s;
            for (int i = 1; i < LOAD_LATENCY; i++) begin
                pipe_vld_r[i]  <= pipe_vld_r[i-1];
                pipe_host_r[i] <= pipe_host_r[i-1];
            end
        end
    end

    assign tail_vld_s   = pipe_vld_r[LOAD_LATENCY-1];
    assign tail_host_s  = pipe_host_r[LOAD_LATENCY-1];
    assign o_core_rvld  = i_mem_rvld & tail_vld_s & ~tail_host_s;
    assign o_host_rvld  = i_mem_rvld & tail_vld_s & tail_host_s;
    assign o_core_rdata = i_mem_rdata;
    assign o_host_rdata = i_mem_rdata;

`ifdef LINE_MEM_ARB_STATS_EN
    logic [15:0] stall_cycles_r;
    logic [15:0] host_grants_r;

    // Saturating statistics counters
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cycles_r <= 16'd0;
            host_grants_r  <= 16'd0;
        end else begin
            if (stall_s && (stall_cycles_r != 16'hFFFF)) begin
                stall_cycles_r <= stall_cycles_r + 16'd1;
            end else begin
                stall_cycles_r <= stall_cycles_r;
            end
            if (host_wins_s && (host_grants_r != 16'hFFFF)) begin
                host_grants_r <= host_grants_r + 16'd1;
            end else begin
                host_grants_r <= host_grants_r;
            end
        end
    end

    assign o_stall_cycles = stall_cycles_r;
    assign o_host_grants  = host_grants_r;
`else
    assign o_stall_cycles = 16'd0;
    assign o_host_grants  = 16'd0;
`endif

endmodule

// File: tb/tb_line_mem_arbiter.sv
// Scoreboard bench for line_mem_arbiter: reference arbitration model, memory responder,
// and a decoupled read-return monitor.
module tb_line_mem_arbiter;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
    localparam int LAT   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          core_re = 1'b0, core_we = 1'b0;
    logic [AW-1:0] core_addr = '0;
    logic [DW-1:0] core_wdata = '0;
    logic          core_stall, core_rvld;
    logic [DW-1:0] core_rdata;
    logic          host_req = 1'b0, host_we = 1'b0, host_lock = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic [DW-1:0] host_wdata = '0;
    logic          host_gnt, host_rvld;
    logic [DW-1:0] host_rdata;
    logic          mem_re, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_rvld = 1'b0;
    logic [15:0]   stall_cycles, host_grants;

    line_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT), .LOAD_LATENCY(LAT)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_core_re(core_re), .i_core_we(core_we), .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .o_core_stall(core_stall), .o_core_rdata(core_rdata), .o_core_rvld(core_rvld),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_lock(host_lock),
        .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_gnt(host_gnt), .o_host_rdata(host_rdata), .o_host_rvld(host_rvld),
        .o_mem_re(mem_re), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .i_mem_rdata(mem_rdata), .i_mem_rvld(mem_rvld),
        .o_stall_cycles(stall_cycles), .o_host_grants(host_grants)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h01000193) ^ 32'hDEADBEEF;
    endfunction

    typedef struct {
        bit          host;
        logic [31:0] data;
        int          due;
    } ret_t;
    ret_t exp_q[$];

    // Memory responder: returns mem_word(addr) exactly LAT cycles after a read
    logic          cap_re = 1'b0;
    logic [AW-1:0] cap_addr = '0;
    logic          rp_v [LAT];
    logic [AW-1:0] rp_a [LAT];
    initial for (int i = 0; i < LAT; i++) begin rp_v[i] = 1'b0; rp_a[i] = '0; end
    always @(negedge clk) begin
        cap_re   = mem_re;
        cap_addr = mem_addr;
    end
    always @(posedge clk) begin
        #1;
        for (int i = LAT - 1; i > 0; i--) begin
            rp_v[i] = rp_v[i-1];
            rp_a[i] = rp_a[i-1];
        end
        rp_v[0]   = cap_re;
        rp_a[0]   = cap_addr;
        mem_rvld  = rp_v[LAT-1];
        mem_rdata = rp_v[LAT-1] ? mem_word(rp_a[LAT-1]) : 32'h0;
    end

    // Monitor: every read return must match the oldest expected one
    always @(negedge clk) begin
        if (core_rvld || host_rvld) begin
            if (exp_q.size() == 0) begin
                check("rvld_unexpected", {30'd0, core_rvld, host_rvld}, 32'd0);
            end else begin
                ret_t e;
                e = exp_q.pop_front();
                check("rvld_owner", {30'd0, core_rvld, host_rvld}, e.host ? 32'd1 : 32'd2);
                check("rdata", e.host ? host_rdata : core_rdata, e.data);
                check("rvld_cycle", cyc, e.due);
            end
        end
    end

    // Reference model state
    bit m_locked = 1'b0;
    int m_wait = 0;
    int m_stalls = 0;
    int m_grants = 0;
    bit e_core, e_host, e_stall;
    logic last_gnt, last_stall;

    task automatic eval_cycle();
        bit creq, e_re, e_we;
        logic [31:0] e_addr, e_wdata;
        int exp_st, exp_hg;
        creq = core_re | core_we;
        e_core = 1'b0;
        e_host = 1'b0;
        if (m_locked) e_host = host_req;
        else if (host_req && m_wait >= LIMIT) e_host = 1'b1;
        else if (creq) e_core = 1'b1;
        else e_host = host_req;
        e_stall = creq && !e_core && (m_locked || creq);
        e_re = e_core ? (core_re && !core_we) : (e_host ? !host_we : 1'b0);
        e_we = e_core ? core_we : (e_host ? host_we : 1'b0);
        e_addr  = e_core ? core_addr : (e_host ? host_addr : 32'h0);
        e_wdata = e_core ? core_wdata : (e_host ? host_wdata : 32'h0);
        check("host_gnt", 32'(host_gnt), 32'(e_host));
        check("core_stall", 32'(core_stall), 32'(e_stall));
        check("mem_re", 32'(mem_re), 32'(e_re));
        check("mem_we", 32'(mem_we), 32'(e_we));
        check("mem_addr", mem_addr, e_addr);
        check("mem_wdata", mem_wdata, e_wdata);
`ifdef LINE_MEM_ARB_STATS_EN
        exp_st = m_stalls;
        exp_hg = m_grants;
`else
        exp_st = 0;
        exp_hg = 0;
`endif
        check("stall_cycles", 32'(stall_cycles), 32'(exp_st));
        check("host_grants", 32'(host_grants), 32'(exp_hg));
        if (e_re) exp_q.push_back('{host: e_host, data: mem_word(e_addr), due: cyc + LAT});
        last_gnt   = host_gnt;
        last_stall = core_stall;
    endtask

    task automatic update_model();
        if (m_locked) m_locked = host_lock;
        else m_locked = e_host && host_lock;
        if (host_req && !e_host) m_wait = (m_wait + 1 > LIMIT) ? LIMIT : m_wait + 1;
        else m_wait = 0;
        if (e_stall && m_stalls < 65535) m_stalls++;
        if (e_host && m_grants < 65535) m_grants++;
    endtask

    task automatic step();
        @(negedge clk);
        eval_cycle();
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle_inputs();
        core_re = 1'b0; core_we = 1'b0;
        host_req = 1'b0; host_we = 1'b0; host_lock = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        exp_q.delete();
        m_locked = 1'b0; m_wait = 0; m_stalls = 0; m_grants = 0;
        @(negedge clk);
        check("rst_host_gnt", 32'(host_gnt), 32'd0);
        check("rst_core_stall", 32'(core_stall), 32'd0);
        check("rst_mem_rewe", {30'd0, mem_re, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        check("rst_rvld", {30'd0, core_rvld, host_rvld}, 32'd0);
        check("rst_stats", {stall_cycles, host_grants}, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic new_core();
        int r;
        r = $urandom_range(0, 4);
        core_re = (r == 2) || (r == 4);
        core_we = (r == 3) || (r == 4);
        core_addr  = $urandom & 32'h0000FFFC;
        core_wdata = $urandom;
    endtask

    task automatic new_host();
        host_req   = ($urandom_range(0, 2) == 0);
        host_we    = $urandom_range(0, 1);
        host_lock  = host_req && ($urandom_range(0, 7) == 0);
        host_addr  = $urandom & 32'h0000FFFC;
        host_wdata = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, grants, first, last;
        bit found;
        do_reset();

        // core-only read
        core_re = 1'b1; core_addr = 32'h10;
        step();
        core_re = 1'b0;
        repeat (LAT + 1) step();

        // contention: host forced through after LIMIT denials, twice in a row
        core_re = 1'b1; core_addr = 32'h20;
        host_req = 1'b1; host_we = 1'b1; host_addr = 32'h300; host_wdata = 32'h1234;
        for (int round = 0; round < 2; round++) begin
            n = 0; found = 1'b0;
            for (int k = 0; k < 12 && !found; k++) begin
                step();
                n++;
                if (last_gnt) found = 1'b1;
                else core_addr = core_addr + 32'd4;
            end
            check("starve_wait", n, LIMIT + 1);
            host_addr = host_addr + 32'd4;
        end
        idle_inputs();
        repeat (LAT + 1) step();

        // lock burst while the core keeps requesting
        core_re = 1'b1; core_addr = 32'h400;
        host_req = 1'b1; host_we = 1'b1; host_lock = 1'b1;
        host_addr = 32'hA0; host_wdata = 32'hA0;
        grants = 0; first = -1; last = -1;
        for (int k = 0; k < 30 && grants < 4; k++) begin
            step();
            if (last_gnt) begin
                if (first < 0) first = k;
                last = k;
                grants++;
                host_addr = host_addr + 32'd1;
                host_wdata = host_wdata + 32'd1;
                if (grants == 4) begin host_req = 1'b0; host_lock = 1'b0; end
            end else if (!last_stall) begin
                core_addr = core_addr + 32'd4;
            end
        end
        check("lock_grants", grants, 32'd4);
        check("lock_span", last - first, 32'd3);
        step();
        check("lock_exit_stall", 32'(last_stall), 32'd1);
        step();
        check("core_after_lock", 32'(last_stall), 32'd0);
        idle_inputs();
        repeat (LAT + 1) step();

        // interleaved core then host reads
        core_re = 1'b1; core_addr = 32'h100;
        step();
        core_re = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h200;
        step();
        idle_inputs();
        repeat (LAT + 2) step();

        // simultaneous re/we is a store only
        core_re = 1'b1; core_we = 1'b1; core_addr = 32'h40; core_wdata = 32'h55AA;
        step();
        idle_inputs();
        repeat (LAT + 2) step();

        // reset while a host read is in flight
        host_req = 1'b1; host_we = 1'b0; host_addr = 32'h280;
        step();
        do_reset();
        repeat (LAT + 2) step();

        // randomized traffic honouring hold-until-accepted
        for (int i = 0; i < 3000; i++) begin
            if (!((core_re || core_we) && last_stall)) new_core();
            if (!(host_req && !last_gnt)) new_host();
            if (i == 1500) begin
                do_reset();
                last_stall = 1'b0;
                last_gnt = 1'b0;
                new_core();
                new_host();
            end
            step();
        end
        idle_inputs();
        repeat (LAT + 3) step();
        check("queue_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Shares the single port of the linear (line) memory between two requesters: the core's load/store path and a host access port used for preload, readback and debug.
- Sits between the core datapath and the line memory.
- Fixed priority to the core, with a starvation guard and a host burst-lock mode.
- Routes returning read data to whichever requester issued the read.

Parameters:
- ADDR_WIDTH, 32, byte/word address width passed to the memory.
- DATA_WIDTH, 32, memory data width.
- STARVE_LIMIT, 4, consecutive denied host cycles before the host is forced through (legal range 1..15).
- LOAD_LATENCY, 1, cycles from o_mem_re to i_mem_rvld (legal range 1..4).

Ports:
- i_clk  in  1  clock
- i_rst  in  1  async reset, active-high
- i_core_re  in  1  core load request
- i_core_we  in  1  core store request
- i_core_addr  in  ADDR_WIDTH  core address
- i_core_wdata  in  DATA_WIDTH  core store data
- o_core_stall  out  1  core request not accepted this cycle
- o_core_rdata  out  DATA_WIDTH  core read data
- o_core_rvld  out  1  core read data valid
- i_host_req  in  1  host access request
- i_host_we  in  1  host write (1) / read (0)
- i_host_lock  in  1  host requests a burst lock
- i_host_addr  in  ADDR_WIDTH  host address
- i_host_wdata  in  DATA_WIDTH  host write data
- o_host_gnt  out  1  host access accepted this cycle
- o_host_rdata  out  DATA_WIDTH  host read data
- o_host_rvld  out  1  host read data valid
- o_mem_re  out  1  memory read enable
- o_mem_we  out  1  memory write enable
- o_mem_addr  out  ADDR_WIDTH  memory address
- o_mem_wdata  out  DATA_WIDTH  memory write data
- i_mem_rdata  in  DATA_WIDTH  memory read data
- i_mem_rvld  in  1  memory read data valid
- o_stall_cycles  out  16  core stall counter (see Optional Feature)
- o_host_grants  out  16  host grant counter (see Optional Feature)

Behaviour:
- Clock/reset: one clock i_clk; i_rst is asynchronous and active-high.
- Reset: FSM=S_IDLE, starve_cnt=0, read-owner tag pipe cleared, stats counters=0. Consequences:
  - o_host_gnt=0, o_core_rvld=0, o_host_rvld=0, o_mem_re=0, o_mem_we=0.
  - o_mem_addr/o_mem_wdata=0.
  - o_core_stall=0 unless the core is requesting.
- Core request creq = i_core_re|i_core_we. If both are set, it is a store (we wins) and no read is issued.
- FSM states S_IDLE, S_CORE, S_HOST, S_LOCK. The state records the previous cycle's owner; arbitration is combinational on the current requests.
- Winner selection, in order:
  - (a) State S_LOCK → host.
  - (b) i_host_req && starve_cnt==STARVE_LIMIT → host.
  - (c) creq → core.
  - (d) i_host_req → host.
  - (e) none.
- Next state:
  - Core wins → S_CORE.
  - Host wins with i_host_lock=1 → S_LOCK.
  - Host wins with i_host_lock=0 → S_HOST.
  - No winner → S_IDLE.
  - S_LOCK exits only when i_host_lock=0: to S_HOST if the host wins that cycle, otherwise to S_IDLE.
- Grants, zero latency:
  - o_host_gnt=1 in the cycle the host wins.
  - o_core_stall = creq && !core_wins.
  - Requesters hold address, data and control stable until accepted.
- Memory outputs: combinational mux of the winner's fields. o_mem_re/o_mem_we are 0 when there is no winner.
- Read routing:
  - LOAD_LATENCY-deep shift register of {valid, owner}, pushed on every cycle with o_mem_re.
  - When i_mem_rvld=1, the tail entry selects o_core_rvld or o_host_rvld. Both rdata outputs carry i_mem_rdata.
  - i_mem_rvld=1 with an invalid tail entry is ignored.
- starve_cnt:
  - Increments when i_host_req && !host_wins, saturating at STARVE_LIMIT.
  - Clears to 0 on host grant or when i_host_req=0.
- Worst-case host wait is STARVE_LIMIT+1 cycles outside S_LOCK.
- In S_LOCK the core is stalled every cycle it requests, even if the host is not requesting.
- Reset asserted mid-burst or mid-read: all in-flight read returns are dropped (no rvld after reset).

Optional Feature:
- Macro: LINE_MEM_ARB_STATS_EN.
- Defined:
  - o_stall_cycles increments on each cycle with o_core_stall=1.
  - o_host_grants increments on each o_host_gnt.
  - Both 16-bit, saturating at 16'hFFFF, cleared by i_rst.
- Undefined: both ports tied to 0 and no counter flops are generated.

Test Plan:
- Core-only: core read addr 0x10, host idle, mem returns 0xDEADBEEF after 1 cycle → o_mem_re=1 with addr 0x10, no stall; o_core_rvld=1 with 0xDEADBEEF one cycle later; o_host_rvld=0.
- Contention: core requests every cycle and host requests continuously, STARVE_LIMIT=4 → host denied 4 cycles; 5th cycle o_host_gnt=1 and o_core_stall=1; starve_cnt returns to 0.
- Lock burst: host writes 0xA0..0xA3 with i_host_lock=1 while the core requests → 4 consecutive grants; core stalled through the cycle after lock drops; core granted next.
- Interleaved reads, LOAD_LATENCY=2: core read, then host read in adjacent cycles → rvld goes to core first, then host, with correct data each.
- Simultaneous i_core_re=i_core_we=1 → store only (o_mem_we=1, o_mem_re=0), no rvld returns.
- Reset during host read in flight → no o_host_rvld afterward. With LINE_MEM_ARB_STATS_EN, counters read 0 after reset and 5 after 5 stall cycles.
